mux_scan: RTL

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan_pkg.sv | 25 ++
 rtl/mux_scan_if.sv | 31 +++
 rtl/mux_scan_ctr.sv | 49 ++++
 rtl/mux_scan.sv | 94 +++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the mux_scan scanner.
// Select width derivation and mode encodings live here so every file agrees.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Select/channel-index width; never narrower than one bit.
    function automatic int sw_of(input int nch);
        return (clog2(nch) < 1) ? 1 : clog2(nch);
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: control, select, packed channel data and the sampled outputs.
// The master side drives controls and data; the slave (the scanner) returns Q/QCH/SOF.
interface mux_scan_if
    import mux_scan_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 1,
    parameter int DW  = 8
);
    localparam int SW = sw_of(NCH);

    logic             CE;
    logic             MODE;
    logic [SW-1:0]    S;
    logic [DW-1:0]    DWELL;
    logic [NCH*W-1:0] D;
    logic [W-1:0]     Q;
    logic [SW-1:0]    QCH;
    logic             SOF;

    modport master (
        output CE, MODE, S, DWELL, D,
        input  Q, QCH, SOF
    );

    modport slave (
        input  CE, MODE, S, DWELL, D,
        output Q, QCH, SOF
    );

endinterface

// File: rtl/mux_scan_ctr.sv
// Channel/dwell sequencer for mux_scan: produces the live select and the start-of-frame decision.
// In manual mode the counter tracks S so a later switch to auto starts from the last selection.
module mux_scan_ctr
    import mux_scan_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int SW  = sw_of(NCH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ce,
    input  logic          i_mode,
    input  logic [SW-1:0] i_s,
    input  logic [DW-1:0] i_dwell,
    output logic [SW-1:0] o_sel,
    output logic          o_sof_next
);

    logic [SW-1:0] r_ch;
    logic [DW-1:0] r_dc;

    always_comb begin
        o_sel      = (i_mode == MODE_AUTO) ? r_ch : i_s;
        o_sof_next = (i_mode == MODE_AUTO) && (r_ch == '0) && (r_dc == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch <= '0;
            r_dc <= '0;
        end else if (i_ce) begin
            if (i_mode == MODE_MANUAL) begin
                r_ch <= i_s;
                r_dc <= '0;
            end else if (r_dc == i_dwell) begin
                r_dc <= '0;
                // Out-of-range channels (from a manual select) also wrap to 0.
                if (int'(r_ch) >= NCH - 1)
                    r_ch <= '0;
                else
                    r_ch <= r_ch + SW'(1);
            end else begin
                r_dc <= r_dc + DW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Multiplexer with manual select or timed auto-scan over NCH channels, registered output.
// Define MUX_SCAN_PIPE_EN to add a second output register stage (latency 2 enabled cycles).
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 1,
    parameter int DW  = 8
) (
    input  logic      CLK,
    input  logic      RST,
    mux_scan_if.slave bus
);

    localparam int SW = sw_of(NCH);

    logic [SW-1:0] w_sel;
    logic          w_sof_next;
    logic [W-1:0]  w_chan [NCH];
    logic [W-1:0]  w_q_next;

    logic [W-1:0]  r_q;
    logic [SW-1:0] r_qch;
    logic          r_sof;

    mux_scan_ctr #(
        .NCH (NCH),
        .DW  (DW),
        .SW  (SW)
    ) u_ctr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_ce       (bus.CE),
        .i_mode     (bus.MODE),
        .i_s        (bus.S),
        .i_dwell    (bus.DWELL),
        .o_sel      (w_sel),
        .o_sof_next (w_sof_next)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign w_chan[gi] = bus.D[gi*W +: W];
        end
    endgenerate

    // A select with no matching channel leaves the sample at zero.
    always_comb begin
        w_q_next = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_sel == SW'(k))
                w_q_next = w_chan[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q   <= '0;
            r_qch <= '0;
            r_sof <= 1'b0;
        end else if (bus.CE) begin
            r_q   <= w_q_next;
            r_qch <= w_sel;
            r_sof <= w_sof_next;
        end
    end

`ifdef MUX_SCAN_PIPE_EN
    logic [W-1:0]  r_q2;
    logic [SW-1:0] r_qch2;
    logic          r_sof2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q2   <= '0;
            r_qch2 <= '0;
            r_sof2 <= 1'b0;
        end else if (bus.CE) begin
            r_q2   <= r_q;
            r_qch2 <= r_qch;
            r_sof2 <= r_sof;
        end
    end

    assign bus.Q   = r_q2;
    assign bus.QCH = r_qch2;
    assign bus.SOF = r_sof2;
`else
    assign bus.Q   = r_q;
    assign bus.QCH = r_qch;
    assign bus.SOF = r_sof;
`endif

endmodule
